mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the shared byte-addressable data memory (256 B, word-aligned read, per-byte write enables) between an instruction-fetch requester and a load/store requester.
- Sequences each access: grant, drive memory, capture, respond.
- Generates byte-lane write enables and replicated store data.
- Extracts and sign/zero-extends load data.
- Sits between the core pipeline and the memory module.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width; fixed at 32, 4 byte lanes.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch byte address
- if_req_ready  out  1  fetch request accepted this cycle
- if_resp_valid  out  1  fetch data valid (1-cycle pulse)
- if_resp_data  out  32  fetched word
- d_req_valid  in  1  data request
- d_req_addr  in  32  data byte address
- d_req_we  in  1  1 = store, 0 = load
- d_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_req_unsigned  in  1  load zero-extend when 1
- d_req_wdata  in  32  store data, right-justified
- d_req_ready  out  1  data request accepted
- d_resp_valid  out  1  data response pulse
- d_resp_data  out  32  load result (0 for stores and errors)
- d_resp_err  out  1  misaligned/illegal, qualified by d_resp_valid
- mem_address  out  32  to memory address
- mem_write_data  out  32  to memory write data
- mem_write_enable  out  4  byte-lane enables
- store_enable  out  1  memory write strobe
- mem_read_data  in  32  combinational read word from memory

Behaviour:
- Reset (async, reset_n = 0): state IDLE, all outputs 0, last_grant = DATA, captured request discarded. store_enable drops immediately; no write occurs on the next edge.
- FSM states:
  - IDLE: ready asserted, per arbitration; transfer when valid & ready; go to ACCESS.
  - ACCESS: one cycle driving memory; go to RESP.
  - RESP: registered response pulse for one cycle; go to IDLE.
- Ready signals are 0 outside IDLE. Throughput: one access per 3 cycles. Latency: accepted at edge N, response valid in cycle N+2.
- Arbitration in IDLE:
  - Only one valid: that requester gets ready.
  - Both valid: grant the requester not equal to last_grant (round-robin); last_grant updates on every transfer.
  - After reset, fetch wins the first tie.
  - Ready depends on valid, so at most one ready is high per cycle.
- Requests are registered at acceptance. Requester inputs may change afterwards without effect.
- Fetch:
  - mem_address = {addr[31:2], 2'b00}; write enables 0.
  - if_resp_data = mem_read_data captured at the end of ACCESS.
- Store in ACCESS: store_enable = 1, mem_address = {addr[31:2], 2'b00}.
  - Byte: enable = 1 << addr[1:0], data = 4 copies of byte.
  - Half: enable = 0011 if addr[1] = 0, else 1100; data = 2 copies of half.
  - Word: enable = 1111, data as is.
  - Memory writes on the edge ending ACCESS.
- Load:
  - Byte: lane addr[1:0] selected, shifted to [7:0].
  - Half: lane addr[1] selected, shifted to [15:0].
  - Word: passed through.
  - Byte and half results are sign-extended unless d_req_unsigned = 1.
- Error:
  - Condition: size 11, half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Still passes through ACCESS, but store_enable = 0 and enables = 0000.
  - RESP raises d_resp_valid with d_resp_err = 1, d_resp_data = 0.
- Outside ACCESS: mem_write_enable = 0000 and store_enable = 0. mem_address holds its last value.
- Exactly one resp_valid pulse per accepted request; never both resp_valid signals high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs conflict_count (16 bits) and store_count (16 bits), cleared at reset.
  - conflict_count increments in each IDLE cycle where both valids are high.
  - store_count increments on each ACCESS cycle with store_enable = 1.
  - Both saturate at 0xFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then fetch addr 0x10 with mem[0x10..0x13] = 0x11,0x22,0x33,0x44 -> if_req_ready in cycle 0; if_resp_data = 0x44332211 in cycle 2.
- Store byte 0xA5 at addr 0x06 -> mem_write_enable = 0100, mem_write_data = 0xA5A5A5A5, store_enable pulse 1 cycle. Then signed byte load at 0x06 -> d_resp_data = 0xFFFFFFA5; unsigned -> 0x000000A5.
- Store half 0xBEEF at 0x0A -> enable 1100. Word load at 0x08 -> upper half = 0xBEEF, lower bytes unchanged.
- Both valid continuously for 4 grants after reset -> grant order IF, D, IF, D; no overlapping responses; conflict_count = 4 with MEM_ARB_STATS_EN.
- Word store at 0x05 -> d_resp_err = 1, d_resp_data = 0, store_enable never asserted, memory unchanged.
- reset_n low during ACCESS of a store -> store_enable drops asynchronously, no write, no response pulse. After release, the fetch requester wins the first tie.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for a shared byte-lane data memory.
// Latency: request accepted at edge N, response pulse in cycle N+2; one access per 3 cycles.
// Backpressure: ready only in IDLE, at most one per cycle. Stats counters built with MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [1:0]        d_req_size,
    input  logic              d_req_unsigned,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              d_resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_write_enable,
    output logic              store_enable,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_ARB_STATS_EN
   ,output logic [15:0]       conflict_count,
    output logic [15:0]       store_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;      // 1 when the data port won the last transfer
    logic              is_fetch_q, is_fetch_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_resp_valid_q, if_resp_valid_d;
    logic              d_resp_valid_q, d_resp_valid_d;
    logic              d_resp_err_q, d_resp_err_d;
    logic [DATA_W-1:0] if_resp_data_q, if_resp_data_d;
    logic [DATA_W-1:0] d_resp_data_q, d_resp_data_d;

    logic              if_grant, d_grant, d_err_in, wr_active;
    logic [3:0]        byte_en;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;

    assign if_grant = (state_q == S_IDLE) && if_req_valid && (!d_req_valid || last_d_q);
    assign d_grant  = (state_q == S_IDLE) && d_req_valid && !if_grant;
    assign d_err_in = (d_req_size == 2'b11)
                   || ((d_req_size == 2'b01) && d_req_addr[0])
                   || ((d_req_size == 2'b10) && (d_req_addr[1:0] != 2'b00));

    always_comb begin
        byte_en  = 4'b0000;
        byte_sel = mem_read_data[7:0];
        half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_val = mem_read_data;
        case (addr_q[1:0])
            2'b01:   byte_sel = mem_read_data[15:8];
            2'b10:   byte_sel = mem_read_data[23:16];
            2'b11:   byte_sel = mem_read_data[31:24];
            default: byte_sel = mem_read_data[7:0];
        endcase
        case (size_q)
            2'b00: begin
                byte_en  = 4'b0001 << addr_q[1:0];
                load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            end
            2'b01: begin
                byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Errored accesses still walk through ACCESS but never touch memory
    assign wr_active        = (state_q == S_ACCESS) && we_q && !err_q;
    assign store_enable     = wr_active;
    assign mem_write_enable = wr_active ? byte_en : 4'b0000;
    assign mem_address      = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        case (size_q)
            2'b00:   mem_write_data = {4{wdata_q[7:0]}};
            2'b01:   mem_write_data = {2{wdata_q[15:0]}};
            default: mem_write_data = wdata_q;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        last_d_d        = last_d_q;
        is_fetch_d      = is_fetch_q;
        we_d            = we_q;
        uns_d           = uns_q;
        err_d           = err_q;
        size_d          = size_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        if_resp_valid_d = 1'b0;
        d_resp_valid_d  = 1'b0;
        d_resp_err_d    = d_resp_err_q;
        if_resp_data_d  = if_resp_data_q;
        d_resp_data_d   = d_resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (if_grant || d_grant) begin
                    state_d    = S_ACCESS;
                    last_d_d   = d_grant;
                    is_fetch_d = if_grant;
                    addr_d     = if_grant ? if_req_addr : d_req_addr;
                    we_d       = d_grant && d_req_we;
                    err_d      = d_grant && d_err_in;
                    size_d     = d_req_size;
                    uns_d      = d_req_unsigned;
                    wdata_d    = d_req_wdata;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (is_fetch_q) begin
                    if_resp_valid_d = 1'b1;
                    if_resp_data_d  = mem_read_data;
                end else begin
                    d_resp_valid_d = 1'b1;
                    d_resp_err_d   = err_q;
                    d_resp_data_d  = (we_q || err_q) ? '0 : load_val;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            last_d_q        <= 1'b1;
            is_fetch_q      <= 1'b0;
            we_q            <= 1'b0;
            uns_q           <= 1'b0;
            err_q           <= 1'b0;
            size_q          <= 2'b00;
            addr_q          <= '0;
            wdata_q         <= '0;
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            d_resp_err_q    <= 1'b0;
            if_resp_data_q  <= '0;
            d_resp_data_q   <= '0;
        end else begin
            state_q         <= state_d;
            last_d_q        <= last_d_d;
            is_fetch_q      <= is_fetch_d;
            we_q            <= we_d;
            uns_q           <= uns_d;
            err_q           <= err_d;
            size_q          <= size_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            if_resp_valid_q <= if_resp_valid_d;
            d_resp_valid_q  <= d_resp_valid_d;
            d_resp_err_q    <= d_resp_err_d;
            if_resp_data_q  <= if_resp_data_d;
            d_resp_data_q   <= d_resp_data_d;
        end
    end

    assign if_req_ready  = if_grant;
    assign d_req_ready   = d_grant;
    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_data  = if_resp_data_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_data   = d_resp_data_q;
    assign d_resp_err    = d_resp_err_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_count_q, conflict_count_d;
    logic [15:0] store_count_q, store_count_d;

    always_comb begin
        conflict_count_d = conflict_count_q;
        store_count_d    = store_count_q;
        if ((state_q == S_IDLE) && if_req_valid && d_req_valid && (conflict_count_q != 16'hFFFF))
            conflict_count_d = conflict_count_q + 16'd1;
        if (wr_active && (store_count_q != 16'hFFFF))
            store_count_d = store_count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conflict_count_q <= '0;
            store_count_q    <= '0;
        end else begin
            conflict_count_q <= conflict_count_d;
            store_count_q    <= store_count_d;
        end
    end

    assign conflict_count = conflict_count_q;
    assign store_count    = store_count_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory model, response scoreboard, reset and arbitration cases.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        d_req_valid = 1'b0;
    logic [31:0] d_req_addr = '0;
    logic        d_req_we = 1'b0;
    logic [1:0]  d_req_size = 2'b00;
    logic        d_req_unsigned = 1'b0;
    logic [31:0] d_req_wdata = '0;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic        store_enable;
    logic [31:0] mem_read_data;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_count;
    logic [15:0] store_count;
`endif

    mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned), .d_req_wdata(d_req_wdata),
        .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .d_resp_err(d_resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .store_enable(store_enable),
        .mem_read_data(mem_read_data)
`ifdef MEM_ARB_STATS_EN
       ,.conflict_count(conflict_count), .store_count(store_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_fetch;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  mem [0:255];
    logic [7:0]  ref_mem [0:255];
    logic [7:0]  ra;

    assign ra = {mem_address[7:2], 2'b00};
    assign mem_read_data = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16: return 8'h11;
            17: return 8'h22;
            18: return 8'h33;
            19: return 8'h44;
            default: return 8'(i);
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    // Memory model: single process owns the array, writes lanes on the edge ending ACCESS
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clock);
            if (store_enable) begin
                for (int l = 0; l < 4; l++)
                    if (mem_write_enable[l]) mem[ra + 8'(l)] = mem_write_data[8*l +: 8];
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (if_resp_valid && d_resp_valid) check("dual_resp", 32'd1, 32'd0);
            if (if_resp_valid || d_resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_src", 32'(if_resp_valid), 32'(e.is_fetch));
                    if (e.is_fetch) begin
                        check("if_data", if_resp_data, e.data);
                    end else begin
                        check("d_data", d_resp_data, e.data);
                        check("d_err", 32'(d_resp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic f_access(input logic [31:0] addr, input logic [31:0] exp_data);
        int w;
        exp_t e;
        @(negedge clock);
        if_req_valid = 1'b1;
        if_req_addr  = addr;
        #1;
        w = 0;
        while (!if_req_ready && w < 20) begin @(negedge clock); #1; w++; end
        check("if_ready_now", 32'(w), 32'd0);
        if (!if_req_ready) begin if_req_valid = 1'b0; return; end
        e.is_fetch = 1'b1; e.data = exp_data; e.err = 1'b0;
        sb.push_back(e);
        @(posedge clock); #1;
        if_req_valid = 1'b0;
        if_req_addr  = $urandom;
        @(negedge clock);
        check("if_lat_access", 32'(if_resp_valid), 32'd0);
        check("if_busy_ready", 32'(if_req_ready), 32'd0);
        @(negedge clock);
        check("if_lat_resp", 32'(if_resp_valid), 32'd1);
    endtask

    task automatic d_access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata, input logic exp_err,
                            input logic [3:0] exp_en, input logic [31:0] exp_wd,
                            input logic [31:0] exp_data);
        int w;
        exp_t e;
        @(negedge clock);
        d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we;
        d_req_size = size; d_req_unsigned = uns; d_req_wdata = wdata;
        #1;
        w = 0;
        while (!d_req_ready && w < 20) begin @(negedge clock); #1; w++; end
        check("d_ready_now", 32'(w), 32'd0);
        if (!d_req_ready) begin d_req_valid = 1'b0; return; end
        e.is_fetch = 1'b0; e.data = exp_data; e.err = exp_err;
        sb.push_back(e);
        @(posedge clock); #1;
        d_req_valid = 1'b0; d_req_addr = $urandom; d_req_wdata = $urandom;
        d_req_we = ~we; d_req_unsigned = ~uns;
        @(negedge clock);
        check("st_en_access", 32'(store_enable), 32'(we && !exp_err));
        check("wr_en_access", 32'(mem_write_enable), 32'(exp_en));
        if (we && !exp_err) begin
            check("wr_data", mem_write_data, exp_wd);
            ref_mem[addr[7:0]] = wdata[7:0];
            if (size != 2'b00) ref_mem[addr[7:0] + 8'd1] = wdata[15:8];
            if (size == 2'b10) begin
                ref_mem[addr[7:0] + 8'd2] = wdata[23:16];
                ref_mem[addr[7:0] + 8'd3] = wdata[31:24];
            end
        end
        @(negedge clock);
        check("st_en_resp", 32'(store_enable), 32'd0);
    endtask

    task automatic check_image(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int grants, cyc;
        logic [3:0] order;
        exp_t e;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

        #12;
        check("rst_if_ready", 32'(if_req_ready), 32'd0);
        check("rst_resp_valid", 32'({if_resp_valid, d_resp_valid}), 32'd0);
        check("rst_st_en", 32'({store_enable, mem_write_enable}), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_d_data", d_resp_data, 32'd0);
        @(negedge clock); reset_n = 1'b1;

        f_access(32'h10, 32'h44332211);
        d_access(32'h06, 1'b1, 2'b00, 1'b0, 32'h123456A5, 1'b0, 4'b0100, 32'hA5A5A5A5, 32'h0);
        d_access(32'h06, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFFA5);
        d_access(32'h06, 1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h000000A5);
        d_access(32'h07, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h00000007);
        d_access(32'h0A, 1'b1, 2'b01, 1'b0, 32'hCAFEBEEF, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0);
        d_access(32'h08, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hBEEF0908);
        d_access(32'h0A, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFBEEF);
        d_access(32'h08, 1'b0, 2'b01, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h00000908);
        d_access(32'h05, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 4'b0000, 32'h0, 32'h0);
        d_access(32'h00, 1'b0, 2'b11, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        d_access(32'h01, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        f_access(32'h05, 32'h07A50504);
        check_image("mem_after_stores");
`ifdef MEM_ARB_STATS_EN
        check("store_count", 32'(store_count), 32'd2);
`endif

        // Reset lands in the middle of an ACCESS cycle of a word store
        @(negedge clock);
        d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b1;
        d_req_size = 2'b10; d_req_wdata = 32'h12345678;
        #1;
        check("abort_ready", 32'(d_req_ready), 32'd1);
        @(posedge clock); #1;
        d_req_valid = 1'b0;
        #1;
        check("abort_st_en_pre", 32'(store_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_st_en_drop", 32'(store_enable), 32'd0);
        check("abort_wr_en_drop", 32'(mem_write_enable), 32'd0);
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_addr = 32'h08; d_req_we = 1'b0;
        d_req_size = 2'b10; d_req_unsigned = 1'b0;
        @(negedge clock); @(negedge clock);
        #2 reset_n = 1'b1;
        #1;
        check("tie_if_ready", 32'(if_req_ready), 32'd1);
        check("tie_d_ready", 32'(d_req_ready), 32'd0);

        grants = 0; cyc = 0; order = 4'b0000;
        while (grants < 4 && cyc < 60) begin
            if (if_req_ready && d_req_ready) check("both_ready", 32'd1, 32'd0);
            if (if_req_ready) begin
                e.is_fetch = 1'b1; e.data = ref_word(8'h10); e.err = 1'b0;
                sb.push_back(e);
                order[grants] = 1'b1;
                grants++;
            end else if (d_req_ready) begin
                e.is_fetch = 1'b0; e.data = ref_word(8'h08); e.err = 1'b0;
                sb.push_back(e);
                grants++;
            end
            @(posedge clock); #1;
            if (grants == 4) begin if_req_valid = 1'b0; d_req_valid = 1'b0; end
            @(negedge clock); #1;
            cyc++;
        end
        check("rr_grants", 32'(grants), 32'd4);
        check("rr_order", 32'(order), 32'b0101);

        repeat (4) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check_image("mem_final");
`ifdef MEM_ARB_STATS_EN
        check("conflict_count", 32'(conflict_count), 32'd4);
        check("store_count_rst", 32'(store_count), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
